// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA raster timing generator: standard mode
// constants, controller state encoding and counter width helper.
package vga_timing_pkg;

   typedef struct packed {
      int   h_active;
      int   h_fp;
      int   h_sync;
      int   h_bp;
      int   v_active;
      int   v_fp;
      int   v_sync;
      int   v_bp;
      logic hs_pol;
      logic vs_pol;
   } vga_mode_t;

   // Asserted sync level is the polarity bit; idle level is its complement.
   localparam vga_mode_t MODE_640X480_60 = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
   localparam vga_mode_t MODE_800X600_60 = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1};

   localparam int PIPE_LAT_MAX = 15;
   localparam int FRAME_CNT_W  = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } vga_state_t;

   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int mode_h_total(input vga_mode_t m);
      return m.h_active + m.h_fp + m.h_sync + m.h_bp;
   endfunction

   function automatic int mode_v_total(input vga_mode_t m);
      return m.v_active + m.v_fp + m.v_sync + m.v_bp;
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous clear; depth 0 is a wire.
module vga_delay_line
   import vga_timing_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             i_clk,
   input  logic             i_clr,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   generate
      if (DEPTH == 0) begin : g_pass
         logic w_unused;
         assign w_unused = ^{i_clk, i_clr};
         assign o_q      = i_d;
      end else begin : g_pipe
         logic [DEPTH-1:0][WIDTH-1:0] r_stage;

         always_ff @(posedge i_clk) begin
            if (i_clr) begin
               r_stage <= '0;
            end else begin
               r_stage[0] <= i_d;
               for (int i = 1; i < DEPTH; i++) begin
                  r_stage[i] <= r_stage[i-1];
               end
            end
         end

         assign o_q = r_stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator with frame-gated enable and a pixel
// request port whose fixed read latency is absorbed ahead of the pins.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE = MODE_640X480_60.h_active,
   parameter int   H_FP     = MODE_640X480_60.h_fp,
   parameter int   H_SYNC   = MODE_640X480_60.h_sync,
   parameter int   H_BP     = MODE_640X480_60.h_bp,
   parameter int   V_ACTIVE = MODE_640X480_60.v_active,
   parameter int   V_FP     = MODE_640X480_60.v_fp,
   parameter int   V_SYNC   = MODE_640X480_60.v_sync,
   parameter int   V_BP     = MODE_640X480_60.v_bp,
   parameter logic HS_POL   = MODE_640X480_60.hs_pol,
   parameter logic VS_POL   = MODE_640X480_60.vs_pol,
   parameter int   PIPE_LAT = 2,
   parameter int   COLOR_W  = 10,
   localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int  X_W      = cnt_w(H_TOTAL),
   localparam int  Y_W      = cnt_w(V_TOTAL)
) (
   input  logic                   CLK_PIX,
   input  logic                   nRst,
   input  logic                   iEn,
   input  logic [COLOR_W-1:0]     iRed,
   input  logic [COLOR_W-1:0]     iGreen,
   input  logic [COLOR_W-1:0]     iBlue,
   output logic                   oReq,
   output logic [X_W-1:0]         oX,
   output logic [Y_W-1:0]         oY,
   output logic                   oFrameStart,
   output logic                   oLineStart,
   output logic [FRAME_CNT_W-1:0] oFrameCnt,
   output logic                   VGA_CLK,
   output logic                   VGA_HS,
   output logic                   VGA_VS,
   output logic                   VGA_BLANK,
   output logic                   VGA_SYNC,
   output logic [COLOR_W-1:0]     VGA_R,
   output logic [COLOR_W-1:0]     VGA_G,
   output logic [COLOR_W-1:0]     VGA_B
);

   generate
      if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
          V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
          PIPE_LAT < 0 || PIPE_LAT > PIPE_LAT_MAX || COLOR_W < 1) begin : g_param_err
         $error("vga_timing_gen: timing parameters must be >=1 and PIPE_LAT in 0..15");
      end
   endgenerate

   localparam logic [X_W-1:0] H_LAST  = X_W'(H_TOTAL - 1);
   localparam logic [X_W-1:0] H_ACT_E = X_W'(H_ACTIVE);
   localparam logic [X_W-1:0] HS_BEG  = X_W'(H_ACTIVE + H_FP);
   localparam logic [X_W-1:0] HS_END  = X_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [Y_W-1:0] V_LAST  = Y_W'(V_TOTAL - 1);
   localparam logic [Y_W-1:0] V_ACT_E = Y_W'(V_ACTIVE);
   localparam logic [Y_W-1:0] VS_BEG  = Y_W'(V_ACTIVE + V_FP);
   localparam logic [Y_W-1:0] VS_END  = Y_W'(V_ACTIVE + V_FP + V_SYNC);

   vga_state_t             r_state;
   vga_state_t             w_state_nxt;
   logic [X_W-1:0]         r_hCnt;
   logic [Y_W-1:0]         r_vCnt;
   logic [FRAME_CNT_W-1:0] r_frameCnt;
   logic                   w_run;
   logic                   w_lastH;
   logic                   w_lastV;
   logic                   w_lastPix;
   logic                   w_hsRaw;
   logic                   w_vsRaw;
   logic [2:0]             w_dly;

   logic                   r_hs;
   logic                   r_vs;
   logic                   r_blank;
   logic [COLOR_W-1:0]     r_red;
   logic [COLOR_W-1:0]     r_green;
   logic [COLOR_W-1:0]     r_blue;

   assign w_run     = (r_state == ST_RUN);
   assign w_lastH   = (r_hCnt == H_LAST);
   assign w_lastV   = (r_vCnt == V_LAST);
   assign w_lastPix = w_run && w_lastH && w_lastV;

   always_ff @(posedge CLK_PIX) begin
      if (!nRst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // iEn is only honoured on the frame boundary while running.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (iEn)               w_state_nxt = ST_RUN;
         ST_RUN:  if (w_lastPix && !iEn) w_state_nxt = ST_IDLE;
         default:                        w_state_nxt = ST_IDLE;
      endcase
   end

   // IDLE pins both counters at 0 so the first RUN cycle is already (0,0).
   always_ff @(posedge CLK_PIX) begin
      if (!nRst || !w_run) begin
         r_hCnt <= '0;
         r_vCnt <= '0;
      end else if (w_lastH) begin
         r_hCnt <= '0;
         r_vCnt <= w_lastV ? '0 : r_vCnt + 1'b1;
      end else begin
         r_hCnt <= r_hCnt + 1'b1;
      end
   end

   always_ff @(posedge CLK_PIX) begin
      if (!nRst) begin
         r_frameCnt <= '0;
      end else if (w_lastPix) begin
         r_frameCnt <= r_frameCnt + 1'b1;
      end
   end

   assign oReq        = w_run && (r_hCnt < H_ACT_E) && (r_vCnt < V_ACT_E);
   assign oX          = oReq ? r_hCnt : '0;
   assign oY          = oReq ? r_vCnt : '0;
   assign oFrameStart = w_run && (r_hCnt == '0) && (r_vCnt == '0);
   assign oLineStart  = w_run && (r_hCnt == '0);
   assign oFrameCnt   = r_frameCnt;

   assign w_hsRaw = w_run && (r_hCnt >= HS_BEG) && (r_hCnt < HS_END);
   assign w_vsRaw = w_run && (r_vCnt >= VS_BEG) && (r_vCnt < VS_END);

   // Syncs and active ride alongside the source's read latency.
   vga_delay_line #(
      .WIDTH (3),
      .DEPTH (PIPE_LAT)
   ) u_align (
      .i_clk (CLK_PIX),
      .i_clr (!nRst),
      .i_d   ({w_hsRaw, w_vsRaw, oReq}),
      .o_q   (w_dly)
   );

   always_ff @(posedge CLK_PIX) begin
      if (!nRst) begin
         r_hs    <= ~HS_POL;
         r_vs    <= ~VS_POL;
         r_blank <= 1'b0;
         r_red   <= '0;
         r_green <= '0;
         r_blue  <= '0;
      end else begin
         r_hs    <= w_dly[2] ? HS_POL : ~HS_POL;
         r_vs    <= w_dly[1] ? VS_POL : ~VS_POL;
         r_blank <= w_dly[0];
         r_red   <= w_dly[0] ? iRed   : '0;
         r_green <= w_dly[0] ? iGreen : '0;
         r_blue  <= w_dly[0] ? iBlue  : '0;
      end
   end

   assign VGA_CLK   = CLK_PIX;
   assign VGA_SYNC  = 1'b1;
   assign VGA_HS    = r_hs;
   assign VGA_VS    = r_vs;
   assign VGA_BLANK = r_blank;
   assign VGA_R     = r_red;
   assign VGA_G     = r_green;
   assign VGA_B     = r_blue;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised raster timing generator for the VGA DAC path; successor to the fixed 640x480 generator.
- Supports any mode through H/V timing parameters and programmable sync polarity.
- Adds a pixel-request interface with latency compensation, so a frame buffer or pattern source with a fixed read latency lines up exactly with the sync and blank outputs.
- Adds frame/line strobes, a frame counter and frame-boundary enable gating.

Parameters:
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch (cycles)
- H_SYNC, 96: horizontal sync width
- H_BP, 48: horizontal back porch
- V_ACTIVE, 480: visible lines
- V_FP, 10: vertical front porch (lines)
- V_SYNC, 2: vertical sync width
- V_BP, 33: vertical back porch
- HS_POL, 0: asserted level of VGA_HS
- VS_POL, 0: asserted level of VGA_VS
- PIPE_LAT, 2: cycles from oReq/oX/oY to valid iRed/iGreen/iBlue (range 0..15)
- COLOR_W, 10: colour channel width

Ports:
- CLK_PIX  in  1  pixel clock; all logic on its rising edge
- nRst  in  1  reset, synchronous, active-low
- iEn  in  1  run enable, sampled only at frame boundary
- iRed, iGreen, iBlue  in  COLOR_W each  pixel colour, valid PIPE_LAT cycles after the matching oReq
- oReq  out  1  pixel request: counter position is in the active region
- oX  out  X_W  request column, X_W = $clog2(H_TOTAL)
- oY  out  Y_W  request row, Y_W = $clog2(V_TOTAL)
- oFrameStart  out  1  one-cycle pulse when the counter is at (0,0) while running
- oLineStart  out  1  one-cycle pulse when hCnt==0 while running
- oFrameCnt  out  16  completed frames, wraps at 0xFFFF -> 0
- VGA_CLK  out  1  equals CLK_PIX
- VGA_HS, VGA_VS  out  1  syncs, aligned with colour
- VGA_BLANK  out  1  high = active video (DAC convention)
- VGA_SYNC  out  1  constant 1
- VGA_R, VGA_G, VGA_B  out  COLOR_W each  gated colour

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Counters:
  - hCnt counts 0..H_TOTAL-1, then wraps to 0.
  - vCnt increments when hCnt wraps and counts 0..V_TOTAL-1.
  - No off-by-one overrun: exactly H_TOTAL*V_TOTAL cycles per frame.
- States:
  - IDLE: counters held at 0; oReq, strobes and active all 0; syncs deasserted.
  - RUN: counting.
- Transitions:
  - IDLE->RUN: iEn=1, on the next cycle (counter at (0,0) that cycle with oFrameStart=1).
  - RUN->IDLE: only when the last pixel of a frame (H_TOTAL-1, V_TOTAL-1) is reached with iEn=0. A deassert mid-frame has no effect until the frame ends.
  - RUN->RUN: the last pixel with iEn=1 wraps to (0,0) and increments oFrameCnt.
- Stage 0, combinational from the counters:
  - oReq = RUN && hCnt<H_ACTIVE && vCnt<V_ACTIVE.
  - oX/oY = hCnt/vCnt when oReq=1, else 0.
  - Raw HS active when H_ACTIVE+H_FP <= hCnt < H_ACTIVE+H_FP+H_SYNC.
  - Raw VS active when V_ACTIVE+V_FP <= vCnt < V_ACTIVE+V_FP+V_SYNC.
- Delay line: raw HS, raw VS and oReq pass through a PIPE_LAT-stage shift register, aligned with the arriving colour.
- Output register, one stage:
  - VGA_HS = delayed HS ? HS_POL : ~HS_POL; VGA_VS likewise with VS_POL.
  - VGA_BLANK = delayed active.
  - VGA_R/G/B = delayed active ? colour : 0.
- Latency: a counter position reaches the VGA pins after PIPE_LAT+1 cycles. PIPE_LAT=0 means colour is sampled in the same cycle as oReq.
- Reset, including mid-frame:
  - Counters and oFrameCnt go to 0, state to IDLE, and all delay stages clear.
  - VGA_R/G/B=0, VGA_BLANK=0, VGA_HS=~HS_POL, VGA_VS=~VS_POL, oReq=0, strobes=0.
  - No partial line is emitted after reset is released.
- Elaboration checks: every timing parameter >=1 and PIPE_LAT<=15; violations fail via $error in a generate block.

Decomposition:
- Shared package vga_timing_pkg:
  - mode constant sets (640x480@60, 800x600@60), each with timings and polarities
  - $clog2-based width helper function
- Sub-module vga_delay_line: parametrised width/depth shift register with synchronous clear, depth 0 = passthrough. Used for the sync/active alignment.

Test Plan:
- Reset release with iEn=1, defaults:
  - oFrameStart pulses once the cycle after iEn is sampled.
  - Next oFrameStart exactly 420000 cycles later; oFrameCnt = 1 after the first wrap.
- HS timing, defaults:
  - Counter hCnt=656 -> VGA_HS falls 3 cycles later and stays low for exactly 96 cycles.
  - VGA_VS low for exactly 2*800 = 1600 cycles starting at line 490 (+3 cycles).
- Latency alignment, PIPE_LAT=2:
  - Source returns iRed = oX[9:0] delayed 2 cycles -> on every cycle with VGA_BLANK=1, VGA_R equals the pixel's column.
  - First visible VGA_R = 0, last = 639; zero outside the active region.
- Mode switch to 800x600 (40/128/88, 1/4/23, positive polarity):
  - frame = 1056*628 cycles; VGA_HS high for 128 cycles; idle level 0.
- Enable gating:
  - Drop iEn at line 100 -> frame completes, generator enters IDLE, oReq stays 0, oFrameCnt frozen.
  - Raise iEn -> restart at (0,0) with an oFrameStart pulse.
- Reset mid-frame at (300,200):
  - Next cycle all outputs are at reset values.
  - After release with iEn=1, the first oFrameStart follows with no stray HS pulse.
